mc_control32: RTL
=================

Name: mc_control32

Overview:
- Multi-cycle sequencer for the Minisys-1 32-bit datapath.
- Decodes the same opcode/function fields as the single-cycle decoder, but steps each instruction through fetch, decode, execute, memory and write-back states. Each state drives per-cycle enables for the PC, IR, register file, ALU muxes and the memory/IO ports.
- Handles a ready handshake for RAM and a fixed wait count for IO accesses.

Parameters:
- IO_WAIT, 2, number of cycles an IO read/write strobe is held; legal values 1..15.
- IO_HIGH, 22'h3FFFFF, Alu_resultHigh value that selects IO space instead of RAM.

Ports:
- clock in 1 system clock, rising edge
- reset in 1 synchronous, active-low reset
- Opcode in 6 IR[31:26], valid from ID onward
- Function_opcode in 6 IR[5:0]
- Alu_resultHigh in 22 ALUOut[31:10], valid in MEM
- Zero in 1 ALU zero flag, valid in EX
- mem_ready in 1 RAM access complete (fetch or data)
- PCWrite out 1 load PC
- PCSource out 2 00 PC+4, 01 ALUOut (branch target), 10 jump target, 11 register rs
- IRWrite out 1 load IR
- IorD out 1 0 instruction address, 1 data address
- MemRead out 1 RAM read strobe
- MemWrite out 1 RAM write strobe
- IORead out 1 IO read strobe
- IOWrite out 1 IO write strobe
- ALUSrcA out 1 0 PC, 1 rs
- ALUSrcB out 2 00 rt, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2
- ALUOp out 2 00 add, 01 subtract/compare, 10 function/opcode decode
- RegWrite out 1 register file write enable
- RegDST out 2 00 rt, 01 rd, 10 $31
- MemIOtoReg out 2 00 ALUOut, 01 MDR, 10 PC (jal link)
- illegal out 1 one-cycle pulse on an undecodable opcode
- state out 3 current FSM state, for debug

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. Outputs are Moore-decoded from the state plus Opcode/Function_opcode/Zero/Alu_resultHigh.
- Reset low at a clock edge: state<=IF, IO wait counter<=0. While reset is low, all outputs are forced to 0 and state reads 0.
- Reset low mid-access drops any strobe within the same cycle; there is no resumption.
- IF:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - If mem_ready=0: stay in IF, with PCWrite=0 and IRWrite=0.
  - If mem_ready=1: IRWrite=1, PCWrite=1, PCSource=00, next state ID.
- ID:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precomputed into ALUOut).
  - j (000010): PCWrite=1, PCSource=10, next state IF.
  - jr (000000/001000): PCWrite=1, PCSource=11, next state IF.
  - jal (000011): next state WB.
  - R-type other than jr, I-type 001xxx, lw 100011, sw 101011, beq 000100, bne 000101: next state EX.
  - Any other opcode: illegal=1 for this cycle, next state IF, PC unchanged from fetch.
- EX:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=10, next state WB. Shifts are decoded by the ALU, not here.
  - I-type: ALUSrcA=1, ALUSrcB=10, ALUOp=10, next state WB.
  - lw/sw: ALUSrcA=1, ALUSrcB=10, ALUOp=00, next state MEM.
  - beq/bne: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PCWrite=1 iff (beq and Zero=1) or (bne and Zero=0). Next state IF.
- MEM:
  - IorD=1. Space is IO if Alu_resultHigh==IO_HIGH, else RAM.
  - RAM access: lw drives MemRead=1, sw drives MemWrite=1. Hold the strobe until mem_ready=1, then go to WB (lw) or IF (sw).
  - IO access: lw drives IORead=1, sw drives IOWrite=1. Counter loads 0 on entry and increments each cycle. Leave when counter==IO_WAIT-1, going to WB (lw) or IF (sw). mem_ready is ignored for IO.
  - IO_WAIT=1 means a single MEM cycle.
- WB:
  - RegWrite=1, next state IF.
  - R-type: RegDST=01, MemIOtoReg=00.
  - I-type: RegDST=00, MemIOtoReg=00.
  - lw: RegDST=00, MemIOtoReg=01.
  - jal: RegDST=10, MemIOtoReg=10, PCWrite=1, PCSource=10 (link and jump in the same cycle).
- Unlisted outputs are 0 in each state. Strobes never overlap: at most one of MemRead/MemWrite/IORead/IOWrite is high.
- Instruction latency in cycles, with zero memory wait:
  - j/jr: 2
  - beq/bne: 3
  - jal: 3
  - R-type/I-type: 4
  - sw: 4
  - lw: 5
- RAM waits add cycles in IF/MEM; IO accesses add IO_WAIT-1 cycles.

Optional Feature:
- Macro MC_RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_cnt[31:0], reset to 0.
  - Increments by 1 on every transition into IF from a non-IF state, except a transition caused by an illegal opcode.
  - Wraps from 32'hFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset held low 3 cycles, then released, mem_ready=1 -> all outputs 0 during reset; IF with MemRead=1 on the first cycle after release; state 0->1 on the next edge.
- add ($0/0x20), mem_ready=1 -> states IF,ID,EX,WB,IF; EX has ALUOp=10 and ALUSrcA=1; WB has RegWrite=1, RegDST=01.
- lw with Alu_resultHigh=0x000001, mem_ready low for 2 MEM cycles -> MemRead held 3 MEM cycles, then WB with MemIOtoReg=01; IORead never high.
- sw with Alu_resultHigh=0x3FFFFF, IO_WAIT=3 -> IOWrite high exactly 3 cycles, then IF; MemWrite stays 0.
- beq with Zero=1, then bne with Zero=1 -> PCWrite=1, PCSource=01 in the first EX; PCWrite=0 in the second EX.
- Opcode 6'b111111 -> illegal pulses for 1 cycle in ID; returns to IF; RegWrite stays 0; retire_cnt unchanged when MC_RETIRE_COUNT_EN is defined.

Source files
------------

// File: rtl/mc_control32.sv
// ---------------------------------------------------------------------------
// mc_control32 -- multi-cycle sequencer for the Minisys-1 32-bit datapath
//
// Steps each instruction through IF -> ID -> EX -> MEM -> WB.  Each
// instruction uses only the states it needs.  Outputs are Moore-decoded from
// the current state plus the instruction fields and the ALU flags.  RAM
// accesses wait on mem_ready.  IO accesses hold their strobe for a fixed
// IO_WAIT cycles.
//
// Parameters
//   IO_WAIT          cycles an IO strobe is held (1..15)
//   IO_HIGH          ALUOut[31:10] value that selects IO space instead of RAM
//
// Optional feature (macro MC_RETIRE_COUNT_EN)
//   When defined, adds retire_cnt, a wrapping count of retired instructions.
//   An instruction retires when the sequencer returns to IF from any other
//   state, unless it returns because of an illegal opcode.
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous active-low reset; all outputs forced to 0
//   Opcode           IR[31:26], valid from ID onward
//   Function_opcode  IR[5:0]
//   Alu_resultHigh   ALUOut[31:10], valid in MEM
//   Zero             ALU zero flag, valid in EX
//   mem_ready        RAM fetch/data access complete
//   PCWrite          load PC
//   PCSource         00 PC+4, 01 ALUOut, 10 jump target, 11 rs
//   IRWrite          load IR
//   IorD             0 instruction address, 1 data address
//   MemRead/MemWrite RAM strobes
//   IORead/IOWrite   IO strobes
//   ALUSrcA          0 PC, 1 rs
//   ALUSrcB          00 rt, 01 const 4, 10 ext imm, 11 imm<<2
//   ALUOp            00 add, 01 subtract, 10 function/opcode decode
//   RegWrite         register file write enable
//   RegDST           00 rt, 01 rd, 10 $31
//   MemIOtoReg       00 ALUOut, 01 MDR, 10 PC (jal link)
//   illegal          one-cycle pulse on an undecodable opcode
//   retire_cnt       retired instruction count (MC_RETIRE_COUNT_EN only)
//   state            current state, for debug
// ---------------------------------------------------------------------------
module mc_control32 #(
    parameter int unsigned IO_WAIT = 2,
    parameter logic [21:0] IO_HIGH = 22'h3FFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Function_opcode,
    input  logic [21:0] Alu_resultHigh,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic [1:0]  PCSource,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IORead,
    output logic        IOWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        RegWrite,
    output logic [1:0]  RegDST,
    output logic [1:0]  MemIOtoReg,
    output logic        illegal,
`ifdef MC_RETIRE_COUNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    // Terminal value of the IO wait counter.  The counter starts at 0 on
    // entry to MEM, so the strobe is held for exactly IO_WAIT cycles.
    localparam logic [3:0] IO_LAST = 4'(IO_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] ioCnt_q, ioCnt_d;

    // Instruction class decode.  This is the same opcode/function decode as
    // the single-cycle controller, reduced to the classes the sequencer needs.
    logic isRType, isJr, isJ, isJal, isIType;
    logic isLw, isSw, isBeq, isBne, goesToEx;
    logic ioSpace;

    always_comb begin
        isRType  = (Opcode == 6'b000000);
        isJr     = isRType && (Function_opcode == 6'b001000);
        isJ      = (Opcode == 6'b000010);
        isJal    = (Opcode == 6'b000011);
        isIType  = (Opcode[5:3] == 3'b001);
        isLw     = (Opcode == 6'b100011);
        isSw     = (Opcode == 6'b101011);
        isBeq    = (Opcode == 6'b000100);
        isBne    = (Opcode == 6'b000101);
        goesToEx = (isRType && !isJr) || isIType || isLw || isSw
                   || isBeq || isBne;
        ioSpace  = (Alu_resultHigh == IO_HIGH);
    end

    // Next-state and output decode.  Every output defaults to 0 and is only
    // raised inside the state that needs it.  Wrapping the whole case in the
    // reset test forces all outputs low while reset is asserted.  It also
    // drops a RAM or IO strobe in the same cycle that reset falls.
    always_comb begin
        state_d    = state_q;
        ioCnt_d    = '0;
        PCWrite    = 1'b0;
        PCSource   = 2'b00;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IORead     = 1'b0;
        IOWrite    = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        RegDST     = 2'b00;
        MemIOtoReg = 2'b00;
        illegal    = 1'b0;
        state      = 3'd0;

        if (!reset) begin
            state_d = S_IF;
        end else begin
            state = state_q;
            unique case (state_q)
                S_IF: begin
                    // The ALU computes PC+4 while the fetch is in flight.
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = S_ID;
                    end
                end

                S_ID: begin
                    // Precompute the branch target into ALUOut.  It is
                    // harmless for instructions that are not branches.
                    ALUSrcB = 2'b11;
                    if (isJ) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b10;
                        state_d  = S_IF;
                    end else if (isJr) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b11;
                        state_d  = S_IF;
                    end else if (isJal) begin
                        state_d = S_WB;
                    end else if (goesToEx) begin
                        state_d = S_EX;
                    end else begin
                        // The PC already advanced in IF.  The bad word is
                        // skipped, not retried.
                        illegal = 1'b1;
                        state_d = S_IF;
                    end
                end

                S_EX: begin
                    ALUSrcA = 1'b1;
                    if (isLw || isSw) begin
                        ALUSrcB = 2'b10;
                        ALUOp   = 2'b00;
                        state_d = S_MEM;
                    end else if (isBeq || isBne) begin
                        ALUSrcB  = 2'b00;
                        ALUOp    = 2'b01;
                        PCSource = 2'b01;
                        PCWrite  = (isBeq && Zero) || (isBne && !Zero);
                        state_d  = S_IF;
                    end else if (isIType) begin
                        ALUSrcB = 2'b10;
                        ALUOp   = 2'b10;
                        state_d = S_WB;
                    end else begin
                        ALUSrcB = 2'b00;
                        ALUOp   = 2'b10;
                        state_d = S_WB;
                    end
                end

                S_MEM: begin
                    IorD = 1'b1;
                    if (ioSpace) begin
                        // IO devices have no ready line, so mem_ready is
                        // ignored and the strobe is held for a fixed time.
                        IORead  = isLw;
                        IOWrite = !isLw;
                        if (ioCnt_q == IO_LAST) begin
                            state_d = isLw ? S_WB : S_IF;
                        end else begin
                            ioCnt_d = ioCnt_q + 4'd1;
                        end
                    end else begin
                        MemRead  = isLw;
                        MemWrite = !isLw;
                        if (mem_ready) begin
                            state_d = isLw ? S_WB : S_IF;
                        end
                    end
                end

                S_WB: begin
                    RegWrite = 1'b1;
                    state_d  = S_IF;
                    if (isJal) begin
                        // Link and jump happen in the same cycle.
                        RegDST     = 2'b10;
                        MemIOtoReg = 2'b10;
                        PCWrite    = 1'b1;
                        PCSource   = 2'b10;
                    end else if (isLw) begin
                        MemIOtoReg = 2'b01;
                    end else if (isRType) begin
                        RegDST = 2'b01;
                    end
                end

                default: begin
                    state_d = S_IF;
                end
            endcase
        end
    end

    // State register and IO wait counter.  The counter is cleared in every
    // state except an IO access in MEM, so it is always 0 on entry to MEM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IF;
            ioCnt_q <= '0;
        end else begin
            state_q <= state_d;
            ioCnt_q <= ioCnt_d;
        end
    end

`ifdef MC_RETIRE_COUNT_EN
    logic [31:0] retireCnt_q, retireCnt_d;

    // Count returns to IF from any other state.  Returns caused by an
    // illegal opcode are not counted.  The count wraps naturally at 2^32.
    always_comb begin
        retireCnt_d = retireCnt_q;
        if (reset && (state_q != S_IF) && (state_d == S_IF) && !illegal) begin
            retireCnt_d = retireCnt_q + 32'd1;
        end
        retire_cnt = reset ? retireCnt_q : 32'd0;
    end

    // Retire counter register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            retireCnt_q <= '0;
        end else begin
            retireCnt_q <= retireCnt_d;
        end
    end
`endif

endmodule
